// File: rtl/heat_pkg.sv
// rtl/heat_pkg.sv - shared colour bins, screen defaults and FSM encoding for the heat-map requester
package heat_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  localparam logic [15:0] TEMP_BLUE_MAX   = 16'h4000;
  localparam logic [15:0] TEMP_GREEN_MAX  = 16'h8000;
  localparam logic [15:0] TEMP_YELLOW_MAX = 16'hC000;

  localparam logic [7:0] CLR_BLUE   = 8'h03;
  localparam logic [7:0] CLR_GREEN  = 8'h1C;
  localparam logic [7:0] CLR_YELLOW = 8'hFC;
  localparam logic [7:0] CLR_RED    = 8'hE0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_MAP     = 3'd3,
    ST_REQ     = 3'd4,
    ST_ACK     = 3'd5,
    ST_ADV     = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/heat_pixel_requester_if.sv
// rtl/heat_pixel_requester_if.sv - arbiter handshake and heat RAM read port of one iterator slot
interface heat_pixel_requester_if;
  logic        inter_start;
  logic        comp_flag;
  logic        inter_select;
  logic        inter_done;
  logic [31:0] vga_addr;
  logic [31:0] vga_pxl_clr;
  logic [18:0] temp_addr;
  logic [15:0] temp_data;

  modport master (
    input  inter_start, comp_flag, temp_data,
    output inter_select, inter_done, vga_addr, vga_pxl_clr, temp_addr
  );

  modport slave (
    output inter_start, comp_flag, temp_data,
    input  inter_select, inter_done, vga_addr, vga_pxl_clr, temp_addr
  );
endinterface

// File: rtl/heat_pixel_requester_colour_map.sv
// rtl/heat_pixel_requester_colour_map.sv - combinational 16-bit temperature to RGB332 bin mapper
module heat_colour_map
  import heat_pkg::*;
(
  input  logic [15:0] temp,
  output logic [7:0]  clr
);

  always_comb begin
    clr = CLR_RED;
    if (temp < TEMP_BLUE_MAX)        clr = CLR_BLUE;
    else if (temp < TEMP_GREEN_MAX)  clr = CLR_GREEN;
    else if (temp < TEMP_YELLOW_MAX) clr = CLR_YELLOW;
  end

endmodule

// File: rtl/heat_pixel_requester.sv
// rtl/heat_pixel_requester.sv - walks interleaved heat-map rows and offers each coloured pixel to the arbiter
module heat_pixel_requester
  import heat_pkg::*;
#(
  parameter int          ITER_ID  = 0,
  parameter int          N_ITER   = 7,
  parameter int          SCREEN_W = SCREEN_W_DEF,
  parameter int          SCREEN_H = SCREEN_H_DEF,
  parameter logic [31:0] VGA_BASE = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  heat_pixel_requester_if.master bus
);

  localparam logic [18:0] OFF_INIT = 19'(ITER_ID * SCREEN_W);
  localparam logic [18:0] ROW_STEP = 19'((N_ITER - 1) * SCREEN_W + 1);
  localparam logic [15:0] X_LAST   = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_INIT   = 16'(ITER_ID);
  localparam logic [15:0] Y_STEP   = 16'(N_ITER);
  localparam logic [15:0] Y_END    = 16'(SCREEN_H);
  localparam bit          EMPTY    = (ITER_ID >= SCREEN_H);

  state_t      state;
  logic [15:0] x;
  logic [15:0] y;
  logic [18:0] off;
  logic [15:0] y_next;
  logic [7:0]  clr_next;

  assign y_next = y + Y_STEP;

  heat_colour_map u_colour_map (
    .temp (bus.temp_data),
    .clr  (clr_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      x                <= '0;
      y                <= '0;
      off              <= '0;
      bus.inter_select <= 1'b0;
      bus.inter_done   <= 1'b0;
      bus.vga_addr     <= '0;
      bus.vga_pxl_clr  <= '0;
      bus.temp_addr    <= '0;
    end else if ((state == ST_IDLE || state == ST_DONE) && bus.inter_start) begin
      // A slot with no rows of its own finishes immediately.
      x              <= '0;
      y              <= Y_INIT;
      off            <= OFF_INIT;
      bus.inter_done <= EMPTY;
      state          <= EMPTY ? ST_DONE : ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          bus.temp_addr <= off;
          state         <= ST_WAIT_RD;
        end
        ST_WAIT_RD: state <= ST_MAP;
        ST_MAP: begin
          bus.vga_pxl_clr  <= {24'b0, clr_next};
          bus.vga_addr     <= VGA_BASE + {13'b0, off};
          bus.inter_select <= 1'b1;
          state            <= ST_REQ;
        end
        ST_REQ: begin
          if (bus.comp_flag) begin
            bus.inter_select <= 1'b0;
            state            <= ST_ACK;
          end
        end
        // Hold off until the grant is released so one pixel is never plotted twice.
        ST_ACK: if (!bus.comp_flag) state <= ST_ADV;
        ST_ADV: begin
          if (x < X_LAST) begin
            x     <= x + 16'd1;
            off   <= off + 19'd1;
            state <= ST_FETCH;
          end else begin
            x   <= '0;
            y   <= y_next;
            off <= off + ROW_STEP;
            if (y_next >= Y_END) begin
              bus.inter_done <= 1'b1;
              state          <= ST_DONE;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heat_pixel_requester.sv
// tb/tb_heat_pixel_requester.sv - self-checking bench for heat_pixel_requester
module tb_heat_pixel_requester;

  typedef struct { logic [31:0] addr; logic [7:0] clr; } pix_t;
  typedef struct { logic [15:0] temp; logic [7:0] clr; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   checks   = 0;
  int   failures = 0;

  pix_t sb0[$];
  pix_t sb1[$];
  int   offs1[8] = '{4, 5, 6, 7, 16, 17, 18, 19};

  heat_pixel_requester_if b0 ();
  heat_pixel_requester_if b1 ();
  heat_pixel_requester_if b2 ();

  heat_pixel_requester #(.ITER_ID(0), .N_ITER(7), .SCREEN_W(1), .SCREEN_H(1), .VGA_BASE(32'h0))
    u0 (.clk(clk), .reset(rst0), .bus(b0.master));
  heat_pixel_requester #(.ITER_ID(1), .N_ITER(3), .SCREEN_W(4), .SCREEN_H(5), .VGA_BASE(32'h0010_0000))
    u1 (.clk(clk), .reset(rst1), .bus(b1.master));
  heat_pixel_requester #(.ITER_ID(7), .N_ITER(8), .SCREEN_W(4), .SCREEN_H(5), .VGA_BASE(32'h0))
    u2 (.clk(clk), .reset(rst2), .bus(b2.master));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Top two bits of the sample select the quarter-range bin.
  function automatic logic [7:0] ref_clr(input logic [15:0] t);
    case (t[15:14])
      2'd0:    return 8'h03;
      2'd1:    return 8'h1C;
      2'd2:    return 8'hFC;
      default: return 8'hE0;
    endcase
  endfunction

  function automatic logic [15:0] ram1(input logic [18:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'h2100;
    return t[15:0];
  endfunction

  task automatic push1_frame();
    pix_t p;
    for (int j = 0; j < 8; j++) begin
      p.addr = 32'h0010_0000 + 32'(offs1[j]);
      p.clr  = ref_clr(ram1(19'(offs1[j])));
      sb1.push_back(p);
    end
  endtask

  always @(posedge clk) b1.temp_data <= ram1(b1.temp_addr);

  // Registered arbiter models: grant one edge after seeing the request, release one edge after it drops.
  logic pend0 = 1'b0;
  always @(negedge clk) begin
    if (!rst0) begin
      b0.comp_flag = 1'b0;
      pend0        = 1'b0;
    end else begin
      if (b0.comp_flag) chk("u0_sel_during_grant", b0.inter_select, 0);
      b0.comp_flag = pend0;
      pend0        = b0.inter_select;
    end
  end

  logic pend1 = 1'b0;
  int   hold1 = 0;
  int   hcnt1 = 0;
  always @(negedge clk) begin
    if (!rst1) begin
      b1.comp_flag = 1'b0;
      pend1        = 1'b0;
      hcnt1        = 0;
    end else begin
      if (b1.comp_flag) chk("u1_sel_during_grant", b1.inter_select, 0);
      if (hcnt1 > 0) begin
        hcnt1--;
      end else begin
        b1.comp_flag = pend1;
        if (pend1 && hold1 > 0) begin
          hcnt1 = hold1;
          hold1 = 0;
        end
      end
      pend1 = b1.inter_select;
    end
  end

  logic        sel0_q = 1'b0, sel1_q = 1'b0, sel2_seen = 1'b0;
  logic [31:0] a1_q, c1_q;
  pix_t        exp0, exp1;
  int          plots1 = 0;

  always @(negedge clk) begin
    if (b0.inter_select && !sel0_q) begin
      checks++;
      if (sb0.size() == 0) begin
        failures++;
        $display("FAIL u0_unexpected_plot: got addr %h expected no plot", b0.vga_addr);
      end else begin
        exp0 = sb0.pop_front();
        chk("u0_plot_addr", b0.vga_addr, exp0.addr);
        chk("u0_plot_clr", b0.vga_pxl_clr, {24'b0, exp0.clr});
      end
    end
    sel0_q = b0.inter_select;

    if (b1.inter_select && !sel1_q) begin
      plots1++;
      checks++;
      if (sb1.size() == 0) begin
        failures++;
        $display("FAIL u1_unexpected_plot: got addr %h expected no plot", b1.vga_addr);
      end else begin
        exp1 = sb1.pop_front();
        chk("u1_plot_addr", b1.vga_addr, exp1.addr);
        chk("u1_plot_clr", b1.vga_pxl_clr, {24'b0, exp1.clr});
      end
    end else if (b1.inter_select && sel1_q) begin
      chk("u1_addr_stable", b1.vga_addr, a1_q);
      chk("u1_clr_stable", b1.vga_pxl_clr, c1_q);
    end
    a1_q   = b1.vga_addr;
    c1_q   = b1.vga_pxl_clr;
    sel1_q = b1.inter_select;

    if (b2.inter_select) sel2_seen = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   n;

    tbl[0] = '{16'h9000, 8'hFC};
    tbl[1] = '{16'h0000, 8'h03};
    tbl[2] = '{16'h3FFF, 8'h03};
    tbl[3] = '{16'h4000, 8'h1C};
    tbl[4] = '{16'h7FFF, 8'h1C};
    tbl[5] = '{16'hC000, 8'hE0};
    tbl[6] = '{16'hFFFF, 8'hE0};

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    b0.inter_start = 1'b0; b1.inter_start = 1'b0; b2.inter_start = 1'b0;
    b0.temp_data = 16'h0; b2.temp_data = 16'h0; b2.comp_flag = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", b0.inter_select, 0);
    chk("rst_done", b0.inter_done, 0);
    chk("rst_addr", b1.vga_addr, 0);
    chk("rst_clr", b1.vga_pxl_clr, 0);
    chk("rst_temp_addr", b1.temp_addr, 0);
    chk("rst_done_empty", b2.inter_done, 0);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    // Single-pixel frame per vector: latency, colour bin and done timing.
    for (int i = 0; i < 7; i++) begin
      b0.temp_data = tbl[i].temp;
      sb0.push_back('{32'h0, tbl[i].clr});
      @(posedge clk); #1 b0.inter_start = 1'b1;
      @(posedge clk); #1 b0.inter_start = 1'b0;
      chk("u0_done_cleared", b0.inter_done, 0);
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        chk("u0_start_latency", b0.inter_select, (k == 3));
      end
      n = 0;
      while (!b0.inter_done && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("u0_done", b0.inter_done, 1);
      chk("u0_done_latency", n, 5);
    end
    chk("u0_sb_empty", sb0.size(), 0);

    // Interleaved rows with a held first grant and a stray mid-frame start.
    hold1 = 5;
    push1_frame();
    @(posedge clk); #1 b1.inter_start = 1'b1;
    @(posedge clk); #1 b1.inter_start = 1'b0;
    n = 0;
    while (!b1.inter_done && n < 400) begin
      b1.inter_start = (n == 30);
      @(posedge clk); #1;
      n++;
    end
    b1.inter_start = 1'b0;
    chk("u1_done", b1.inter_done, 1);
    chk("u1_sb_empty", sb1.size(), 0);
    chk("u1_plot_count", plots1, 8);
    repeat (4) @(posedge clk);
    #1;
    chk("u1_done_held", b1.inter_done, 1);

    // Asynchronous reset while a request is pending.
    @(posedge clk); #1 b1.inter_start = 1'b1;
    @(posedge clk); #1 b1.inter_start = 1'b0;
    n = 0;
    while (!b1.inter_select && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u1_reached_req", b1.inter_select, 1);
    rst1 = 1'b0;
    #1;
    chk("u1_rst_sel", b1.inter_select, 0);
    chk("u1_rst_done", b1.inter_done, 0);
    chk("u1_rst_addr", b1.vga_addr, 0);
    chk("u1_rst_clr", b1.vga_pxl_clr, 0);
    chk("u1_rst_temp_addr", b1.temp_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b1;
    push1_frame();
    @(posedge clk); #1 b1.inter_start = 1'b1;
    @(posedge clk); #1 b1.inter_start = 1'b0;
    n = 0;
    while (!b1.inter_done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u1_restart_done", b1.inter_done, 1);
    chk("u1_restart_sb_empty", sb1.size(), 0);

    // Slot beyond the last row.
    @(posedge clk); #1 b2.inter_start = 1'b1;
    @(posedge clk); #1 b2.inter_start = 1'b0;
    chk("u2_done_next_cycle", b2.inter_done, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("u2_done_held", b2.inter_done, 1);
    chk("u2_never_selected", sel2_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
